// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters, looked up from Fetch
// and trained from Execute; also flags mispredicts and keeps saturating branch statistics.
module branch_target_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   PCF,
    output logic              PredTakenF,
    output logic [XLEN-1:0]   PredTargetF,
    input  logic              BranchE,
    input  logic              BranchTakenE,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   BranchTargetE,
    input  logic              PredTakenE,
    input  logic [XLEN-1:0]   PredTargetE,
    output logic              MispredictE,
    output logic [XLEN-1:0]   RedirectPCE,
    output logic [STAT_W-1:0] BranchCount,
    output logic [STAT_W-1:0] MispredictCount
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntWeakT = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CntWeakN = CntWeakT - CNT_W'(1);

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [XLEN-1:0]   tgt_q   [ENTRIES];
    logic [CNT_W-1:0]  cnt_q   [ENTRIES];

    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]  f_idx, e_idx;
    logic [TAG_W-1:0]  f_tag, e_tag;
    logic              f_hit, e_hit;

    logic              ent_we;
    logic [TAG_W-1:0]  ent_tag_d;
    logic [XLEN-1:0]   ent_tgt_d;
    logic [CNT_W-1:0]  ent_cnt_d;

    logic              unused_lsbs;
    assign unused_lsbs = ^{PCF[1:0], PCE[1:0]};

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[XLEN-1:IDX_W+2];
    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[XLEN-1:IDX_W+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    // Lookup reads pre-update state; there is deliberately no bypass from the Execute write.
    always_comb begin
        PredTakenF  = !reset && f_hit && cnt_q[f_idx][CNT_W-1];
        PredTargetF = PredTakenF ? tgt_q[f_idx] : '0;
    end

    always_comb begin
        MispredictE = !reset && BranchE &&
                      ((PredTakenE != BranchTakenE) ||
                       (BranchTakenE && PredTakenE && (PredTargetE != BranchTargetE)));
        RedirectPCE = BranchTakenE ? BranchTargetE : PCE + XLEN'(4);
    end

    always_comb begin
        ent_we    = 1'b0;
        ent_tag_d = e_tag;
        ent_tgt_d = tgt_q[e_idx];
        ent_cnt_d = cnt_q[e_idx];
        if (BranchE && !reset) begin
            if (e_hit) begin
                ent_we = 1'b1;
                if (BranchTakenE) begin
                    ent_tgt_d = BranchTargetE;
                    if (cnt_q[e_idx] != CntMax) ent_cnt_d = cnt_q[e_idx] + CNT_W'(1);
                end else if (cnt_q[e_idx] != '0) begin
                    ent_cnt_d = cnt_q[e_idx] - CNT_W'(1);
                end
            end else if (BranchTakenE) begin
                // Allocation evicts whatever entry currently aliases this index.
                ent_we    = 1'b1;
                ent_tgt_d = BranchTargetE;
                ent_cnt_d = CntWeakT;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (BranchE && !reset && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + STAT_W'(1);
        if (MispredictE && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= CntWeakN;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (ent_we) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= ent_tag_d;
                tgt_q[e_idx]   <= ent_tgt_d;
                cnt_q[e_idx]   <= ent_cnt_d;
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = mispred_cnt_q;

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage pipelined core. Looks up the Fetch-stage PC in the same cycle, supplying a predicted-taken flag and target that select the next PC, and is trained from resolved branches in Execute. On a wrong prediction it raises a mispredict flag and supplies the corrected PC for the hazard unit's flush/redirect. Saturating statistics counters expose branch and mispredict totals.

## Interface
Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB entries; power of two, >= 2. IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width, >= 1.
- STAT_W, 16, statistics counter width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- PCF  input  XLEN  Fetch-stage PC to look up.
- PredTakenF  output  1  prediction for PCF: taken.
- PredTargetF  output  XLEN  predicted target; 0 when PredTakenF=0.
- BranchE  input  1  valid, unflushed branch resolved in Execute this cycle.
- BranchTakenE  input  1  actual direction.
- PCE  input  XLEN  PC of the Execute branch.
- BranchTargetE  input  XLEN  actual target (ALU result).
- PredTakenE  input  1  PredTakenF carried down with the instruction.
- PredTargetE  input  XLEN  PredTargetF carried down with the instruction.
- MispredictE  output  1  Execute branch was mispredicted.
- RedirectPCE  output  XLEN  correct next PC for the Execute branch.
- BranchCount  output  STAT_W  resolved branches, saturating.
- MispredictCount  output  STAT_W  mispredicts, saturating.

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2]; PC[1:0] ignored.
- Entry = {valid, tag, target[XLEN], counter[CNT_W]}.
- Lookup, combinational on PCF: hit = valid & tag match. PredTakenF = hit & counter[CNT_W-1]. PredTargetF = PredTakenF ? target : 0.
- Update, sequential, only when BranchE=1:
  - Hit, taken: counter increments, saturating at all-ones; target <= BranchTargetE.
  - Hit, not taken: counter decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate, overwriting any aliasing entry: valid=1, tag, target=BranchTargetE, counter=2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- MispredictE = BranchE & ((PredTakenE != BranchTakenE) | (BranchTakenE & PredTakenE & (PredTargetE != BranchTargetE))).
- RedirectPCE = BranchTakenE ? BranchTargetE : PCE + 4, truncated modulo 2^XLEN.
- Statistics: BranchCount += 1 when BranchE; MispredictCount += 1 when MispredictE. Both saturate at 2^STAT_W-1.
- The block drives no stall or flush signals; the hazard unit consumes MispredictE.

## Timing
- Lookup latency 0: PredTakenF/PredTargetF are valid in the same cycle as PCF.
- Update latency 1: a write in cycle N is visible to lookups from cycle N+1.
- Same-index lookup and update in one cycle: lookup returns pre-update contents. No bypass.
- MispredictE and RedirectPCE are combinational from the E inputs, with no register.
- Reset, taking effect at the clock edge:
  - All valid bits 0.
  - Counters 2^(CNT_W-1)-1 (weakly not taken; 0 when CNT_W=1).
  - Targets and tags 0; statistics 0.
- While reset=1:
  - PredTakenF=0, PredTargetF=0, MispredictE=0.
  - RedirectPCE still follows the formula.
  - No updates.
- Reset asserted mid-run discards all training. The first cycle after deassertion behaves as cold.
- Counter wrap never occurs: both direction and statistics counters saturate.

## Test plan
- Cold miss: after reset, PCF=0x40 -> PredTakenF=0. BranchE at PCE=0x40, taken, target 0x80 -> MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x80.
- Training/saturation (CNT_W=2): four taken updates at 0x40 -> counter 3. Three not-taken updates -> counter 0, PredTakenF=0. A fourth not-taken leaves counter 0.
- Not-taken mispredict: entry predicts taken, BranchE at PCE=0x40 not taken -> MispredictE=1, RedirectPCE=0x44.
- Target change: hit, taken, PredTargetE=0x80, BranchTargetE=0xC0 -> MispredictE=1. Next lookup gives PredTargetF=0xC0.
- Aliasing (ENTRIES=16): 0x40 is trained. Lookup 0x80 (same index, different tag) -> PredTakenF=0. Taken update at 0x80 evicts it; lookup 0x40 -> miss.
- Same-cycle/reset: PCF=PCE=0x40 on the first allocation -> PredTakenF=0 that cycle, 1 the next. Reset mid-run -> all lookups miss, counters read 0. With STAT_W=2, five branches -> BranchCount=3.
